apb_regfile: RTL
================

APB_REGFILE -- requirements
Module: apb_regfile

Interface
REQ-001 DWIDTH, 32, register/PWDATA/PRDATA width in bits; SHALL be a multiple of 8.
REQ-002 NREGS, 8, number of RW registers; SHALL be >= 1.
REQ-003 AWIDTH, 8, PADDR byte-address width.
REQ-004 WAIT_STATES, 0, PREADY-low cycles inserted in every ACCESS phase; range 0..15.
REQ-005 PCLK  input  1  clock; all state updates on rising edge.
REQ-006 PRESETn  input  1  reset; asynchronous, active-low.
REQ-007 PSEL  input  1  slave select.
REQ-008 PENABLE  input  1  APB access-phase strobe.
REQ-009 PWRITE  input  1  1 = write, 0 = read.
REQ-010 PADDR  input  AWIDTH  byte address.
REQ-011 PWDATA  input  DWIDTH  write data.
REQ-012 PSTRB  input  DWIDTH/8  byte-lane write enables; present only under APB_REGFILE_PSTRB_EN.
REQ-013 PRDATA  output  DWIDTH  read data.
REQ-014 PREADY  output  1  transfer-complete.
REQ-015 PSLVERR  output  1  error response, valid only with PREADY.
REQ-016 regs_out  output  NREGS*DWIDTH  all register contents; register i at bits [i*DWIDTH +: DWIDTH].
REQ-017 wr_pulse  output  NREGS  one-cycle per-register write-commit flags.

Function
REQ-018 Register index SHALL be PADDR >> log2(DWIDTH/8); low offset bits ignored.
REQ-019 FSM SHALL have states IDLE and ACCESS; IDLE -> ACCESS on an edge sampling PSEL=1, PENABLE=0.
REQ-020 In ACCESS a wait counter SHALL increment from 0 each cycle; PREADY SHALL be combinationally high only when state=ACCESS and counter=WAIT_STATES.
REQ-021 Transfer SHALL complete on the edge sampling PSEL=PENABLE=PREADY=1; FSM -> IDLE, counter -> 0; back-to-back transfer SHALL start from IDLE on the following setup cycle.
REQ-022 PSEL=0 while in ACCESS SHALL abort to IDLE with no write and no wr_pulse.
REQ-023 Write commit SHALL occur on the completing edge; new value visible on regs_out in the next cycle; wr_pulse[idx] high exactly that one next cycle.
REQ-024 PRDATA SHALL equal register[idx] while PREADY=1 and PWRITE=0, else 0.
REQ-025 idx >= NREGS: PSLVERR=1 with PREADY, write discarded, no wr_pulse, PRDATA=0.
REQ-026 WAIT_STATES=0: PREADY high in first ACCESS cycle (standard two-cycle APB transfer).

Reset
REQ-027 PRESETn low SHALL immediately force all registers, regs_out, PRDATA, PREADY, PSLVERR, wr_pulse to 0, FSM to IDLE, counter to 0.
REQ-028 Reset asserted mid-transfer SHALL abort it with no register change; first post-reset transfer SHALL behave normally.

Configuration
REQ-029 With APB_REGFILE_PSTRB_EN defined: PSTRB exists; only byte lanes with PSTRB[b]=1 update; PSTRB=0 write changes nothing and SHALL NOT raise wr_pulse; PSTRB ignored on reads.
REQ-030 Without APB_REGFILE_PSTRB_EN: PSTRB absent; every write updates all DWIDTH bits.

Structure
REQ-031 Package apb_regfile_pkg SHALL hold the FSM state typedef, MAX_WAIT_STATES=15 constant and the wait-counter width.
REQ-032 One sub-module apb_reg_cell (one DWIDTH register with byte-lane enables and wr_pulse) SHALL be instantiated NREGS times.

Verification
REQ-033 Write 0xDEADBEEF to 0x04, WAIT_STATES=0 -> PREADY in 2nd cycle, regs_out reg1=0xDEADBEEF, wr_pulse=8'b0000_0010 for one cycle.
REQ-034 Read 0x04 after REQ-033 with WAIT_STATES=3 -> PREADY low 3 ACCESS cycles, then PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-035 Write 0x55 to 0x40 (idx 16, NREGS=8) -> PSLVERR=1 with PREADY, all registers unchanged, wr_pulse=0.
REQ-036 PSTRB_EN: reg2=0x11223344, write 0xAABBCCDD PSTRB=4'b0101 -> reg2=0x11BB33DD.
REQ-037 PRESETn low in 2nd ACCESS cycle of a write (WAIT_STATES=3) -> all outputs 0, register unchanged; next read returns 0.
REQ-038 Drop PSEL in ACCESS during write -> FSM IDLE, no update, no wr_pulse.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// apb_regfile_pkg
// Shared types and constants for the APB register file.
//   apb_state_e     : two-state transfer FSM encoding (IDLE / ACCESS)
//   MAX_WAIT_STATES : largest supported number of PREADY-low ACCESS cycles
//   WAIT_CNT_W      : width of the ACCESS-phase wait counter
// Configuration macro used elsewhere in the block: APB_REGFILE_PSTRB_EN
// -----------------------------------------------------------------------------
package apb_regfile_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

endpackage : apb_regfile_pkg

// File: rtl/apb_regfile_if.sv
// -----------------------------------------------------------------------------
// apb_regfile_if
// APB bus bundle between a requester and the register file.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : requester -> register file
//   PSTRB                                : byte-lane enables, only when
//                                          APB_REGFILE_PSTRB_EN is defined
//   PRDATA, PREADY, PSLVERR              : register file -> requester
// Modports: master (requester side), slave (register file side).
// -----------------------------------------------------------------------------
interface apb_regfile_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
);

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
`ifdef APB_REGFILE_PSTRB_EN
    logic [DWIDTH/8-1:0] PSTRB;
`endif
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
`ifdef APB_REGFILE_PSTRB_EN
        output PSTRB,
`endif
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR
    );

    modport slave (
`ifdef APB_REGFILE_PSTRB_EN
        input  PSTRB,
`endif
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PRDATA,
        output PREADY,
        output PSLVERR
    );

endinterface : apb_regfile_if

// File: rtl/apb_reg_cell.sv
// -----------------------------------------------------------------------------
// apb_reg_cell
// One DWIDTH-bit read/write register with byte-lane write enables.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   we            : write commit for this register (one cycle)
//   byte_en       : per-byte lane enables for the commit
//   wdata         : write data
//   q             : current register contents
//   wr_pulse      : high for the single cycle after a commit that touched
//                   at least one byte lane
// -----------------------------------------------------------------------------
module apb_reg_cell #(
    parameter int DWIDTH = 32
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                we,
    input  logic [DWIDTH/8-1:0] byte_en,
    input  logic [DWIDTH-1:0]   wdata,
    output logic [DWIDTH-1:0]   q,
    output logic                wr_pulse
);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            q        <= '0;
            wr_pulse <= 1'b0;
        end else begin
            // A commit with no lanes enabled is not a write at all.
            wr_pulse <= we && (|byte_en);
            if (we) begin
                for (int b = 0; b < DWIDTH/8; b++) begin
                    if (byte_en[b]) begin
                        q[b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule : apb_reg_cell

// File: rtl/apb_regfile.sv
// -----------------------------------------------------------------------------
// apb_regfile
// APB slave exposing NREGS read/write registers with optional wait states.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   apb           : APB slave bus (apb_regfile_if.slave)
//   regs_out      : all registers, register i at [i*DWIDTH +: DWIDTH]
//   wr_pulse      : per-register one-cycle flag after a committed write
// Parameters: DWIDTH (multiple of 8), NREGS (>= 1), AWIDTH, WAIT_STATES (0..15)
// Optional feature: define APB_REGFILE_PSTRB_EN to honour PSTRB byte lanes;
// without it every write replaces the full register.
// -----------------------------------------------------------------------------
module apb_regfile
    import apb_regfile_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int NREGS       = 8,
    parameter int AWIDTH      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    apb_regfile_if.slave            apb,
    output logic [NREGS*DWIDTH-1:0] regs_out,
    output logic [NREGS-1:0]        wr_pulse
);

    localparam int STRB_W    = DWIDTH / 8;
    localparam int IDX_SHIFT = $clog2(STRB_W);

    localparam logic [WAIT_CNT_W-1:0] WAIT_TGT = WAIT_CNT_W'(WAIT_STATES);
    // One extra bit so NREGS == 2**AWIDTH still compares correctly.
    localparam logic [AWIDTH:0]       NREGS_L  = (AWIDTH + 1)'(NREGS);

    apb_state_e            state;
    apb_state_e            state_nx;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nx;

    logic [AWIDTH-1:0]     idx;
    logic                  idx_valid;
    logic                  ready;
    logic                  complete;
    logic [STRB_W-1:0]     strb;
    logic [NREGS-1:0]      we_vec;
    logic [DWIDTH-1:0]     rd_word;

    // Word index from the byte address; sub-word offset bits are dropped.
    assign idx       = apb.PADDR >> IDX_SHIFT;
    assign idx_valid = ({1'b0, idx} < NREGS_L);

    assign ready    = (state == ACCESS) && (wait_cnt == WAIT_TGT);
    assign complete = ready && apb.PSEL && apb.PENABLE;

`ifdef APB_REGFILE_PSTRB_EN
    assign strb = apb.PSTRB;
`else
    assign strb = '1;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // A dropped PSEL in ACCESS abandons the transfer without committing.
    // PSEL held with PENABLE low in ACCESS is a bus error by the requester;
    // the slave simply keeps waiting.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        case (state)
            IDLE: begin
                wait_cnt_nx = '0;
                if (apb.PSEL && !apb.PENABLE) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb.PSEL || complete) begin
                    state_nx    = IDLE;
                    wait_cnt_nx = '0;
                end else if (wait_cnt != WAIT_TGT) begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nx    = IDLE;
                wait_cnt_nx = '0;
            end
        endcase
    end

    always_comb begin
        we_vec = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (complete && apb.PWRITE && idx_valid && (idx == AWIDTH'(i))) begin
                we_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == AWIDTH'(i)) begin
                rd_word = regs_out[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign apb.PREADY  = ready;
    assign apb.PSLVERR = ready && !idx_valid;
    assign apb.PRDATA  = (ready && !apb.PWRITE && idx_valid) ? rd_word : '0;

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        apb_reg_cell #(
            .DWIDTH(DWIDTH)
        ) u_cell (
            .PCLK     (PCLK),
            .PRESETn  (PRESETn),
            .we       (we_vec[i]),
            .byte_en  (strb),
            .wdata    (apb.PWDATA),
            .q        (regs_out[i*DWIDTH +: DWIDTH]),
            .wr_pulse (wr_pulse[i])
        );
    end

endmodule : apb_regfile
